// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive NRZI decode / bit-unstuff path.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_RECV         = 2'd1,
        ST_EXPECT_STUFF = 2'd2,
        ST_ERR          = 2'd3
    } rx_state_t;

    localparam int unsigned STUFF_LIMIT = 6;
    localparam int unsigned BYTE_BITS   = 8;
    localparam int unsigned ONES_W      = 3;
    localparam int unsigned IDX_W       = $clog2(BYTE_BITS);

    // A line level equal to the previous one means a decoded 1.
    function automatic logic nrzi_decode(input logic level, input logic prev_level);
        return ~(level ^ prev_level);
    endfunction

endpackage

// File: rtl/unstuff_ones_counter.sv
// Consecutive-ones counter, saturating at STUFF_LIMIT; hit_o flags the enable that reaches it.
module unstuff_ones_counter
    import usb_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic count_en_i,
    output logic hit_o
);

    localparam logic [ONES_W-1:0] LIMIT    = ONES_W'(STUFF_LIMIT);
    localparam logic [ONES_W-1:0] LIMIT_M1 = ONES_W'(STUFF_LIMIT - 1);

    logic [ONES_W-1:0] cnt_q;
    logic [ONES_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + ONES_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Combinational so the FSM can move to EXPECT_STUFF on the same edge as the 6th one.
    assign hit_o = count_en_i && !clear_i && (cnt_q == LIMIT_M1);

endmodule

// File: rtl/usb_rx_unstuff.sv
// USB RX NRZI decoder and bit unstuffer with LSB-first byte assembly.
// bit/byte outputs are registered one cycle after the accepted shift_en strobe.
module usb_rx_unstuff
    import usb_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       d_in,
    input  logic       shift_en,
    input  logic       rx_active,
    output logic       bit_out,
    output logic       bit_valid,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       stuff_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_BITS - 1);

    rx_state_t            state_q;
    logic                 prev_level_q;
    logic [IDX_W-1:0]     idx_q;
    logic [BYTE_BITS-1:0] shreg_q;

    logic                 accept;
    logic                 decoded;
    logic                 ones_clear;
    logic                 ones_en;
    logic                 ones_hit;
    logic [BYTE_BITS-1:0] shreg_nxt;

    assign accept    = shift_en && rx_active &&
                       ((state_q == ST_RECV) || (state_q == ST_EXPECT_STUFF));
    assign decoded   = nrzi_decode(d_in, prev_level_q);
    assign shreg_nxt = {decoded, shreg_q[BYTE_BITS-1:1]};

    assign ones_en    = accept && (state_q == ST_RECV) && decoded;
    assign ones_clear = !rx_active ||
                        (accept && ((state_q == ST_EXPECT_STUFF) || !decoded));

    unstuff_ones_counter u_ones (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (ones_clear),
        .count_en_i (ones_en),
        .hit_o      (ones_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prev_level_q <= 1'b1;
            idx_q        <= '0;
            shreg_q      <= '0;
            bit_out      <= 1'b0;
            bit_valid    <= 1'b0;
            rx_byte      <= 8'h00;
            byte_valid   <= 1'b0;
            stuff_err    <= 1'b0;
        end else begin
            bit_valid  <= 1'b0;
            byte_valid <= 1'b0;
            if (!rx_active) begin
                // Packet end wins over a coincident strobe; partial byte is dropped.
                state_q      <= ST_IDLE;
                prev_level_q <= 1'b1;
                idx_q        <= '0;
                shreg_q      <= '0;
                stuff_err    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_RECV;
                    end
                    ST_RECV: begin
                        if (accept) begin
                            prev_level_q <= d_in;
                            bit_out      <= decoded;
                            bit_valid    <= 1'b1;
                            shreg_q      <= shreg_nxt;
                            idx_q        <= idx_q + IDX_W'(1);
                            if (idx_q == LAST_IDX) begin
                                rx_byte    <= shreg_nxt;
                                byte_valid <= 1'b1;
                            end
                            if (ones_hit) begin
                                state_q <= ST_EXPECT_STUFF;
                            end
                        end
                    end
                    ST_EXPECT_STUFF: begin
                        if (accept) begin
                            prev_level_q <= d_in;
                            if (decoded) begin
                                stuff_err <= 1'b1;
                                state_q   <= ST_ERR;
                            end else begin
                                state_q   <= ST_RECV;
                            end
                        end
                    end
                    ST_ERR: begin
                        state_q <= ST_ERR;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_unstuff.sv
// Randomized and directed bench for usb_rx_unstuff against a run-length reference model.
module tb_usb_rx_unstuff;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_in;
    logic       shift_en;
    logic       rx_active;
    logic       bit_out;
    logic       bit_valid;
    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       stuff_err;

    int checks   = 0;
    int failures = 0;

    bit         stim_q[$];
    bit         keep_q[$];
    bit         exp_bits[$];
    logic [7:0] exp_bytes[$];
    bit         exp_err;
    bit         got_bits[$];
    logic [7:0] got_bytes[$];
    logic       line_prev;

    usb_rx_unstuff dut (
        .clk        (clk),
        .rst        (rst),
        .d_in       (d_in),
        .shift_en   (shift_en),
        .rx_active  (rx_active),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .stuff_err  (stuff_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bit_valid === 1'b1) got_bits.push_back(bit_out);
        if (byte_valid === 1'b1) begin
            got_bytes.push_back(rx_byte);
            chk("byte_with_bit", {31'd0, bit_valid}, 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) stim_q.push_back(v[i]);
    endtask

    // Reference: after six consecutive kept ones the next decoded bit is a stuff bit.
    task automatic build_model();
        int         ones = 0;
        int         n    = 0;
        bit         err  = 0;
        logic [7:0] acc  = 8'h00;
        keep_q.delete();
        exp_bits.delete();
        exp_bytes.delete();
        foreach (stim_q[i]) begin
            if (err) begin
                keep_q.push_back(1'b0);
            end else if (ones == 6) begin
                keep_q.push_back(1'b0);
                if (stim_q[i]) err = 1'b1;
                else ones = 0;
            end else begin
                keep_q.push_back(1'b1);
                exp_bits.push_back(stim_q[i]);
                ones   = stim_q[i] ? ones + 1 : 0;
                acc[n] = stim_q[i];
                n++;
                if (n == 8) begin
                    exp_bytes.push_back(acc);
                    n = 0;
                end
            end
        end
        exp_err = err;
    endtask

    task automatic send_bit(input bit b);
        d_in      = b ? line_prev : ~line_prev;
        line_prev = d_in;
        shift_en  = 1'b1;
        tick();
        shift_en  = 1'b0;
    endtask

    task automatic send_packet(input string tag);
        build_model();
        got_bits.delete();
        got_bytes.delete();
        line_prev = 1'b1;
        rx_active = 1'b1;
        tick();
        tick();
        foreach (stim_q[i]) begin
            send_bit(stim_q[i]);
            chk({tag, "_lat"}, {31'd0, bit_valid}, {31'd0, keep_q[i]});
            repeat ($urandom_range(0, 3)) tick();
        end
        tick();
        tick();
        chk({tag, "_err"}, {31'd0, stuff_err}, {31'd0, exp_err});
        rx_active = 1'b0;
        tick();
        chk({tag, "_err_clr"}, {31'd0, stuff_err}, 32'd0);
        tick();
        chk({tag, "_nbits"}, got_bits.size(), exp_bits.size());
        chk({tag, "_nbytes"}, got_bytes.size(), exp_bytes.size());
        for (int i = 0; i < exp_bits.size() && i < got_bits.size(); i++)
            chk({tag, "_bit"}, {31'd0, got_bits[i]}, {31'd0, exp_bits[i]});
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
            chk({tag, "_byte"}, {24'd0, got_bytes[i]}, {24'd0, exp_bytes[i]});
        stim_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bit_out"},    {31'd0, bit_out},    32'd0);
        chk({tag, "_bit_valid"},  {31'd0, bit_valid},  32'd0);
        chk({tag, "_rx_byte"},    {24'd0, rx_byte},    32'd0);
        chk({tag, "_byte_valid"}, {31'd0, byte_valid}, 32'd0);
        chk({tag, "_stuff_err"},  {31'd0, stuff_err},  32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        d_in      = 1'b1;
        shift_en  = 1'b0;
        rx_active = 1'b0;
        line_prev = 1'b1;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Alternating line levels: eight decoded zeros.
        push_bits(32'h0, 8);
        send_packet("zeros");
        chk("zeros_byte", got_bytes.size() > 0 ? {24'd0, got_bytes[0]} : 32'hx, 32'h00);

        // Six ones, stuffed zero, two ones.
        push_bits(32'h1BF, 9);
        send_packet("ff_stuffed");
        chk("ff_byte", got_bytes.size() > 0 ? {24'd0, got_bytes[0]} : 32'hx, 32'hFF);

        // Seven ones: stuff violation, then trailing bits must be suppressed.
        push_bits(32'h7F, 7);
        push_bits(32'h2, 3);
        send_packet("stuff_viol");
        chk("viol_nbits", got_bits.size(), 32'd6);

        // Aborted partial byte, then a full byte from index 0.
        push_bits(32'h0D, 5);
        send_packet("partial");
        push_bits(32'hA5, 8);
        send_packet("after_partial");
        chk("a5_byte", got_bytes.size() > 0 ? {24'd0, got_bytes[0]} : 32'hx, 32'hA5);

        // 0x3F with its stuffed zero, then next byte starting with 1.
        push_bits(32'h23F, 10);
        push_bits(32'h0, 7);
        send_packet("h3f");
        chk("h3f_byte", got_bytes.size() > 0 ? {24'd0, got_bytes[0]} : 32'hx, 32'h3F);

        // Stuff bit straddling a byte boundary.
        push_bits(32'hFC, 8);
        push_bits(32'h0, 1);
        push_bits(32'h01, 8);
        send_packet("boundary");

        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) stim_q.push_back($urandom_range(0, 3) != 0);
            send_packet("rand");
        end

        // Reset mid-byte with a coincident strobe.
        got_bits.delete();
        got_bytes.delete();
        line_prev = 1'b1;
        rx_active = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 8; i++) send_bit(((8'hA5 >> i) & 8'h1) != 0);
        tick();
        chk("pre_rst_byte", {24'd0, rx_byte}, 32'hA5);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        rst      = 1'b1;
        d_in     = ~d_in;
        shift_en = 1'b1;
        tick();
        shift_en = 1'b0;
        chk_all_zero("mid_rst");
        rst       = 1'b0;
        rx_active = 1'b0;
        tick();
        tick();

        push_bits(32'h5A, 8);
        send_packet("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
